// File: rtl/hc595_pkg.sv
// Shared types and widths for the HC595 serial driver.
package hc595_pkg;

    localparam int unsigned HC595_DIV_W = 8;
    localparam int unsigned HC595_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } hc595_state_e;

endpackage

// File: rtl/hc595_phase_tick.sv
// DIV-cycle phase counter; tick is high on the last cycle of every phase.
module hc595_phase_tick
    import hc595_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic sclr_n,
    input  logic restart,
    output logic tick
);

    localparam logic [HC595_DIV_W-1:0] LAST = HC595_DIV_W'(DIV - 1);

    logic [HC595_DIV_W-1:0] cnt_q, cnt_d;
    logic                   tick_q, tick_d;

    // Tick is registered: it is precomputed from the count about to be loaded.
    always_comb begin
        cnt_d = cnt_q + HC595_DIV_W'(1);
        if (restart || tick_q) begin
            cnt_d = '0;
        end
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/hc595_driver.sv
// Shifts one frame out to a chain of 74HC595 stages, then pulses rck to latch it.
// HC595_DRIVER_LSB_FIRST_EN: send din[0] first instead of din[WIDTH-1].
module hc595_driver
    import hc595_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             sclr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             oe_en,
    output logic             si,
    output logic             sck,
    output logic             rck,
    output logic             g_n,
    output logic             busy,
    output logic             done
);

    if (DIV == 0 || DIV > 255) begin : g_bad_div
        $error("hc595_driver: DIV must be in 1..255");
    end
    if (WIDTH == 0 || WIDTH > 32) begin : g_bad_width
        $error("hc595_driver: WIDTH must be in 1..32");
    end

    hc595_state_e           state_q;
    logic [WIDTH-1:0]       sr_q;
    logic [HC595_CNT_W-1:0] cnt_q;
    logic                   si_q, sck_q, rck_q, g_n_q, busy_q, done_q, din_ready_q;

    logic                   phase_restart;
    logic                   phase_tick;
    logic [WIDTH-1:0]       sr_adv;
    logic                   din_first;
    logic                   adv_bit;

`ifdef HC595_DRIVER_LSB_FIRST_EN
    assign sr_adv    = sr_q >> 1;
    assign din_first = din[0];
    assign adv_bit   = sr_adv[0];
`else
    assign sr_adv    = sr_q << 1;
    assign din_first = din[WIDTH-1];
    assign adv_bit   = sr_adv[WIDTH-1];
`endif

    // Phase counter is held cleared while idle so every frame starts on a fresh phase.
    assign phase_restart = (state_q == IDLE);

    hc595_phase_tick #(
        .DIV(DIV)
    ) u_phase_tick (
        .clk    (clk),
        .sclr_n (sclr_n),
        .restart(phase_restart),
        .tick   (phase_tick)
    );

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            si_q        <= 1'b0;
            sck_q       <= 1'b0;
            rck_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (din_valid && din_ready_q) begin
                        sr_q        <= din;
                        si_q        <= din_first;
                        cnt_q       <= HC595_CNT_W'(WIDTH - 1);
                        state_q     <= SHIFT_LO;
                        busy_q      <= 1'b1;
                        din_ready_q <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (phase_tick) begin
                        sck_q   <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    // si only moves on the falling sck edge, keeping it stable at the rise.
                    if (phase_tick) begin
                        sck_q <= 1'b0;
                        if (cnt_q == '0) begin
                            rck_q   <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            cnt_q   <= cnt_q - HC595_CNT_W'(1);
                            sr_q    <= sr_adv;
                            si_q    <= adv_bit;
                            state_q <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (phase_tick) begin
                        rck_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        din_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output enable is a plain one-cycle registered inversion, independent of the FSM.
    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            g_n_q <= 1'b1;
        end else begin
            g_n_q <= ~oe_en;
        end
    end

    assign si        = si_q;
    assign sck       = sck_q;
    assign rck       = rck_q;
    assign g_n       = g_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign din_ready = din_ready_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Scoreboard bench for hc595_driver driving a behavioural 74HC595 model.
module tb_hc595_driver;

    localparam int unsigned W    = 8;
    localparam int unsigned DIV  = 4;
    localparam int unsigned DIV1 = 1;
    localparam int unsigned LAT  = (2 * W + 1) * DIV;
    localparam int unsigned LAT1 = (2 * W + 1) * DIV1;

    logic       clk = 1'b0;
    logic       sclr_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       oe_en = 1'b0;
    logic       din_ready, si, sck, rck, g_n, busy, done;

    logic [7:0] din1 = 8'h00;
    logic       din_valid1 = 1'b0;
    logic       din_ready1, si1, sck1, rck1, g_n1, busy1, done1;

    hc595_driver #(.WIDTH(W), .DIV(DIV)) dut (
        .clk(clk), .sclr_n(sclr_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .oe_en(oe_en), .si(si), .sck(sck), .rck(rck),
        .g_n(g_n), .busy(busy), .done(done)
    );

    hc595_driver #(.WIDTH(W), .DIV(DIV1)) dut1 (
        .clk(clk), .sclr_n(sclr_n), .din(din1), .din_valid(din_valid1),
        .din_ready(din_ready1), .oe_en(1'b0), .si(si1), .sck(sck1), .rck(rck1),
        .g_n(g_n1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value seen on qh..qa once a frame has been latched.
    function automatic logic [7:0] order(input logic [7:0] v);
`ifdef HC595_DRIVER_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
`else
        return v;
`endif
    endfunction

    // Behavioural 74HC595 chains
    logic [7:0] m_sr = 8'h00, m_st = 8'h00;
    logic [7:0] m1_sr = 8'h00, m1_st = 8'h00;
    always @(posedge sck)  m_sr  <= {m_sr[6:0], si};
    always @(posedge rck)  m_st  <= m_sr;
    always @(posedge sck1) m1_sr <= {m1_sr[6:0], si1};
    always @(posedge rck1) m1_st <= m1_sr;

    // Scoreboard monitor
    logic [7:0] exp_q[$];
    logic [7:0] bits = 8'h00;
    logic [7:0] e;
    int   acc_edge = 0, last_sck_rise = 0, rck_rise = 0, rck_width = 0, nrise = 0;
    logic sck_p = 1'b0, rck_p = 1'b0, overlap = 1'b0;

    always @(negedge clk) begin
        if (!sclr_n) begin
            sck_p = 1'b0;
            rck_p = 1'b0;
        end else begin
            if (sck && !sck_p) begin
                bits = {bits[6:0], si};
                nrise++;
                last_sck_rise = cyc;
            end
            if (rck && !rck_p) rck_rise = cyc;
            if (rck) rck_width++;
            if (sck && rck) overlap = 1'b1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with empty queue (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("storage", 32'(m_st), 32'(e));
                    check("si_bits", 32'(bits), 32'(e));
                    check("latency", 32'(cyc - acc_edge), 32'(LAT));
                    check("rck_width", 32'(rck_width), 32'(DIV));
                    check("rck_after_sck", 32'(rck_rise - last_sck_rise), 32'(DIV));
                    check("sck_rck_overlap", 32'(overlap), 32'(0));
                end
            end
            if (din_valid && din_ready) begin
                acc_edge  = cyc + 1;
                bits      = 8'h00;
                nrise     = 0;
                rck_width = 0;
                overlap   = 1'b0;
            end
            sck_p = sck;
            rck_p = rck;
        end
    end

    task automatic send(input logic [7:0] f, input bit keep_valid, output bit in_done);
        bit ok;
        ok = 1'b0;
        in_done = 1'b0;
        din = f;
        din_valid = 1'b1;
        exp_q.push_back(order(f));
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (din_ready) begin
                in_done = done;
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!keep_valid) din_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d, d2, seen1;
        int acc1;

        // Reset values
        #22;
        check("reset_pins", 32'({si, sck, rck, g_n}), 32'(4'b0001));
        check("reset_status", 32'({busy, done, din_ready}), 32'(3'b001));
        sclr_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame
        send(8'hA5, 1'b0, d);
        check("busy_in_flight", 32'(busy), 32'(1));
        wait_done();

        // Back-to-back frames with din_valid held
        send(8'h3C, 1'b1, d);
        din = 8'h81;
        send(8'h81, 1'b0, d2);
        check("b2b_accept_in_done", 32'(d2), 32'(1));
        wait_done();

        // Reset during bit 5 of 8'hFF
        send(8'hFF, 1'b0, d);
        for (int i = 0; i < 300 && !(nrise == 5 && !sck); i++) @(negedge clk);
        #2;
        sclr_n = 1'b0;
        #1;
        check("midreset_pins", 32'({si, sck, rck, g_n}), 32'(4'b0001));
        check("midreset_status", 32'({busy, done, din_ready}), 32'(3'b001));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("storage_kept", 32'(m_st), 32'(order(8'h81)));
        sclr_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame after reset, with oe_en toggling while it is in flight
        send(8'h0F, 1'b0, d);
        oe_en = 1'b1;
        @(negedge clk);
        check("g_n_before_on", 32'(g_n), 32'(1));
        @(negedge clk);
        check("g_n_on", 32'(g_n), 32'(0));
        check("busy_during_oe", 32'(busy), 32'(1));
        @(posedge clk);
        #1;
        oe_en = 1'b0;
        @(negedge clk);
        check("g_n_before_off", 32'(g_n), 32'(0));
        @(negedge clk);
        check("g_n_off", 32'(g_n), 32'(1));
        wait_done();

        // DIV=1 instance
        din1 = 8'h01;
        din_valid1 = 1'b1;
        @(posedge clk);
        #1;
        acc1 = cyc;
        din_valid1 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 100 && !seen1; i++) begin
            @(negedge clk);
            if (done1) seen1 = 1'b1;
        end
        check("div1_done_seen", 32'(seen1), 32'(1));
        check("div1_latency", 32'(cyc - acc1), 32'(LAT1));
        check("div1_ready_in_done", 32'(din_ready1), 32'(1));
        check("div1_storage", 32'(m1_st), 32'(order(8'h01)));

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
